// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: PREPARE/PLAY/END mode control,
// snake length and cherry score tracking, eat lockout and end-of-game hold.
module snake_game_ctrl #(
    parameter int unsigned INIT_SIZE = 3,
    parameter int unsigned MAX_SIZE  = 31,
    parameter int unsigned EAT_LOCK  = 100000,
    parameter int unsigned END_HOLD  = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       userStart,
    input  logic       snakeEatCherry,
    input  logic       bump,
    input  logic       restart,
    output logic       gamePrepare,
    output logic       gameStart,
    output logic       gameEnd,
    output logic [4:0] size,
    output logic [7:0] score,
    output logic       win
);

    localparam int unsigned LOCK_W = (EAT_LOCK > 1) ? $clog2(EAT_LOCK) : 1;
    localparam int unsigned HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(EAT_LOCK - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(END_HOLD - 1);
    localparam logic [4:0]        SIZE_INIT = 5'(INIT_SIZE);
    localparam logic [4:0]        SIZE_MAX  = 5'(MAX_SIZE);

    typedef enum logic [1:0] {
        S_PREPARE = 2'd0,
        S_PLAY    = 2'd1,
        S_END     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [4:0]          size_q, size_d;
    logic [7:0]          score_q, score_d;
    logic                win_q, win_d;
    logic                prep_q, prep_d;
    logic                play_q, play_d;
    logic                end_q, end_d;

    logic [3:0] in_lvl;
    logic [3:0] rise;
    logic       rise_start, rise_eat, rise_bump, rise_restart;
    logic [4:0] size_inc;

    assign in_lvl       = {userStart, snakeEatCherry, bump, restart};
    assign rise         = in_lvl & ~prev_q;
    assign rise_start   = rise[3];
    assign rise_eat     = rise[2];
    assign rise_bump    = rise[1];
    assign rise_restart = rise[0];
    assign size_inc     = size_q + 5'd1;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d = state_q;
        prev_d  = in_lvl;
        lock_d  = (lock_q != '0) ? lock_q - LOCK_W'(1) : lock_q;
        hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        size_d  = size_q;
        score_d = score_q;
        win_d   = win_q;

        unique case (state_q)
            S_PREPARE: begin
                if (rise_start) begin
                    state_d = S_PLAY;
                    lock_d  = '0;
                end
            end
            S_PLAY: begin
                // A collision wins over a simultaneous eat
                if (rise_bump) begin
                    state_d = S_END;
                    win_d   = 1'b0;
                    hold_d  = '0;
                end else if (rise_eat && lock_q == '0) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    size_d  = size_inc;
                    lock_d  = LOCK_LOAD;
                    if (size_inc == SIZE_MAX) begin
                        state_d = S_END;
                        win_d   = 1'b1;
                        hold_d  = '0;
                    end
                end
            end
            S_END: begin
                if ((rise_restart || rise_start) && hold_q == HOLD_MAX) begin
                    state_d = S_PREPARE;
                    size_d  = SIZE_INIT;
                    score_d = 8'd0;
                    win_d   = 1'b0;
                end
            end
            default: state_d = S_PREPARE;
        endcase

        prep_d = (state_d == S_PREPARE);
        play_d = (state_d == S_PLAY);
        end_d  = (state_d == S_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PREPARE;
            prev_q  <= '0;
            lock_q  <= '0;
            hold_q  <= '0;
            size_q  <= SIZE_INIT;
            score_q <= 8'd0;
            win_q   <= 1'b0;
            prep_q  <= 1'b1;
            play_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            lock_q  <= lock_d;
            hold_q  <= hold_d;
            size_q  <= size_d;
            score_q <= score_d;
            win_q   <= win_d;
            prep_q  <= prep_d;
            play_q  <= play_d;
            end_q   <= end_d;
        end
    end

    assign gamePrepare = prep_q;
    assign gameStart   = play_q;
    assign gameEnd     = end_q;
    assign size        = size_q;
    assign score       = score_q;
    assign win         = win_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Table-driven bench for snake_game_ctrl with INIT_SIZE=3, MAX_SIZE=8,
// EAT_LOCK=8, END_HOLD=16; expectations are hand-derived per record.
module tb_snake_game_ctrl;

    localparam logic [2:0] MP = 3'b001;
    localparam logic [2:0] ML = 3'b010;
    localparam logic [2:0] ME = 3'b100;

    typedef struct {
        logic       rst;
        logic       us;
        logic       eat;
        logic       bmp;
        logic       rs;
        int         reps;
        logic [2:0] mode;
        logic [4:0] size;
        logic [7:0] score;
        logic       win;
    } vec_t;

    typedef struct {
        int         id;
        logic [2:0] mode;
        logic [4:0] size;
        logic [7:0] score;
        logic       win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       userStart = 1'b0;
    logic       snakeEatCherry = 1'b0;
    logic       bump = 1'b0;
    logic       restart = 1'b0;
    logic       gamePrepare, gameStart, gameEnd, win;
    logic [4:0] size;
    logic [7:0] score;

    int n_vec = 0;
    int n_err = 0;
    int vid   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .INIT_SIZE(3), .MAX_SIZE(8), .EAT_LOCK(8), .END_HOLD(16)
    ) dut (
        .clk(clk), .rst(rst), .userStart(userStart),
        .snakeEatCherry(snakeEatCherry), .bump(bump), .restart(restart),
        .gamePrepare(gamePrepare), .gameStart(gameStart), .gameEnd(gameEnd),
        .size(size), .score(score), .win(win)
    );

    task automatic add(input logic r, input logic u, input logic e, input logic b,
                       input logic s, input int n, input logic [2:0] m,
                       input int sz, input int sc, input logic w);
        vec_t v;
        v.rst = r; v.us = u; v.eat = e; v.bmp = b; v.rs = s; v.reps = n;
        v.mode = m; v.size = 5'(sz); v.score = 8'(sc); v.win = w;
        tbl.push_back(v);
    endtask

    // Hold one input pattern for v.reps cycles, then compare outputs
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        for (int r = 0; r < v.reps; r++) begin
            @(negedge clk);
            rst = v.rst; userStart = v.us; snakeEatCherry = v.eat;
            bump = v.bmp; restart = v.rs;
            if (r == v.reps - 1) begin
                e.id = vid; e.mode = v.mode; e.size = v.size;
                e.score = v.score; e.win = v.win;
                sb.push_back(e);
            end
            @(posedge clk);
        end
        #1;
        got = sb.pop_front();
        n_vec++;
        if ({gameEnd, gameStart, gamePrepare} !== got.mode || size !== got.size ||
            score !== got.score || win !== got.win) begin
            n_err++;
            $display("FAIL vec%0d: mode=%b size=%0d score=%0d win=%b, required mode=%b size=%0d score=%0d win=%b",
                     got.id, {gameEnd, gameStart, gamePrepare}, size, score, win,
                     got.mode, got.size, got.score, got.win);
        end
        vid++;
    endtask

    initial begin
        vec_t v;
        // Reset, then a held start level yields one transition
        add(1,0,0,0,0, 2, MP,3,0,0);
        add(0,0,0,0,0, 1, MP,3,0,0);
        add(0,1,0,0,0, 1, ML,3,0,0);
        add(0,1,0,0,0, 9, ML,3,0,0);
        add(0,0,0,0,0, 1, ML,3,0,0);
        // Eat lockout: pulses at relative cycles 0, 4, 10
        add(0,0,1,0,0, 1, ML,4,1,0);
        add(0,0,0,0,0, 3, ML,4,1,0);
        add(0,0,1,0,0, 1, ML,4,1,0);
        add(0,0,0,0,0, 5, ML,4,1,0);
        add(0,0,1,0,0, 1, ML,5,2,0);
        add(0,0,0,0,0, 8, ML,5,2,0);
        // Simultaneous bump and eat, then end hold
        add(0,0,1,1,0, 1, ME,5,2,0);
        add(0,0,0,0,0, 4, ME,5,2,0);
        add(0,0,0,0,1, 1, ME,5,2,0);
        add(0,0,0,0,0,14, ME,5,2,0);
        add(0,0,0,0,1, 1, MP,3,0,0);
        add(0,0,1,1,1, 1, MP,3,0,0);
        // Win at MAX_SIZE=8 from size 3
        add(0,1,0,0,0, 1, ML,3,0,0);
        add(0,0,1,0,0, 1, ML,4,1,0);
        add(0,0,0,0,0, 8, ML,4,1,0);
        add(0,0,1,0,0, 1, ML,5,2,0);
        add(0,0,0,0,0, 8, ML,5,2,0);
        add(0,0,1,0,0, 1, ML,6,3,0);
        add(0,0,0,0,0, 8, ML,6,3,0);
        add(0,0,1,0,0, 1, ML,7,4,0);
        add(0,0,0,0,0, 8, ML,7,4,0);
        add(0,0,1,0,0, 1, ME,8,5,1);
        add(0,0,0,0,0, 8, ME,8,5,1);
        add(0,0,1,0,0, 1, ME,8,5,1);
        add(0,0,0,0,0, 1, ME,8,5,1);
        add(0,1,0,0,0, 1, ME,8,5,1);
        add(0,0,0,0,0, 5, ME,8,5,1);
        add(0,1,0,0,0, 1, MP,3,0,0);
        // Reset mid-game with lockout active
        add(0,0,0,0,0, 1, MP,3,0,0);
        add(0,1,0,0,0, 1, ML,3,0,0);
        add(0,0,1,0,0, 1, ML,4,1,0);
        add(0,0,0,0,0, 8, ML,4,1,0);
        add(0,0,1,0,0, 1, ML,5,2,0);
        add(0,0,0,0,0, 8, ML,5,2,0);
        add(0,0,1,0,0, 1, ML,6,3,0);
        add(0,0,0,0,0, 8, ML,6,3,0);
        add(0,0,1,0,0, 1, ML,7,4,0);
        add(1,0,0,0,0, 1, MP,3,0,0);
        add(0,1,0,0,0, 1, ML,3,0,0);
        add(0,0,1,0,0, 1, ML,4,1,0);
        // Reset during the end hold
        add(0,0,0,1,0, 1, ME,4,1,0);
        add(1,0,0,0,0, 1, MP,3,0,0);

        foreach (tbl[i]) apply(tbl[i]);

        // Hand sequence: a long eat level counts once, bump level ends once
        v = '{rst:0, us:1, eat:0, bmp:0, rs:0, reps:1,  mode:ML, size:5'd3, score:8'd0, win:0};
        apply(v);
        v = '{rst:0, us:0, eat:1, bmp:0, rs:0, reps:20, mode:ML, size:5'd4, score:8'd1, win:0};
        apply(v);
        v = '{rst:0, us:0, eat:1, bmp:1, rs:0, reps:3,  mode:ME, size:5'd4, score:8'd1, win:0};
        apply(v);
        // Restart held high across hold expiry gives no rise, so stays in END
        v = '{rst:0, us:0, eat:0, bmp:0, rs:1, reps:20, mode:ME, size:5'd4, score:8'd1, win:0};
        apply(v);
        v = '{rst:0, us:0, eat:0, bmp:0, rs:0, reps:1,  mode:ME, size:5'd4, score:8'd1, win:0};
        apply(v);
        v = '{rst:0, us:0, eat:0, bmp:0, rs:1, reps:1,  mode:MP, size:5'd3, score:8'd0, win:0};
        apply(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
